// File: rtl/prog_counter_pkg.sv
// Shared encodings for the programmable counter: operating modes and the
// one-shot state machine states.
package prog_counter_pkg;

   // Operating modes carried on the 2-bit mode port; 2'b11 is reserved and
   // behaves as wrap.
   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   // One-shot sequencing states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/prog_counter_prescaler.sv
// Prescaler: produces one tick every div+1 enabled cycles. The count only
// advances while en is high, and restart forces it back to zero so a clear,
// load or one-shot start begins a fresh prescale period.
module prescaler #(
   parameter int unsigned DIV_WIDTH = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 en,
   input  logic                 restart,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH-1:0] cnt_d;

   // Next prescale count; a count above a newly lowered div folds back to 0
   // instead of running all the way around the counter range.
   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q >= div) ? '0 : cnt_q + DIV_WIDTH'(1);
      end
   end

   // Prescale count register with asynchronous reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && (cnt_q == div);

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, wrap/saturate/one-shot modes,
// synchronous clear and load, and a registered terminal-count pulse.
module prog_counter
   import prog_counter_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DIV_WIDTH = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 en,
   input  logic                 clear,
   input  logic                 load,
   input  logic [WIDTH-1:0]     load_val,
   input  logic [WIDTH-1:0]     limit,
   input  logic                 dir,
   input  logic [1:0]           mode,
   input  logic                 start,
   input  logic [DIV_WIDTH-1:0] div,
   output logic [WIDTH-1:0]     out,
   output logic                 tc,
   output logic                 busy
);

   logic [WIDTH-1:0] out_q, out_d;
   logic             tc_q, tc_d;
   state_e           state_q, state_d;

   logic             tick;
   logic             restart;
   logic             is_sat;
   logic             is_oneshot;
   logic [WIDTH-1:0] term_val;
   logic [WIDTH-1:0] step_val;
   logic             at_term;

   prescaler #(
      .DIV_WIDTH(DIV_WIDTH)
   ) u_prescaler (
      .clock  (clock),
      .reset_n(reset_n),
      .en     (en),
      .restart(restart),
      .div    (div),
      .tick   (tick)
   );

   assign is_sat     = (mode == MODE_SAT);
   assign is_oneshot = (mode == MODE_ONESHOT);

   // Terminal value and the candidate result of one step in the current
   // direction; an out above limit folds to 0 going up.
   always_comb begin
      term_val = dir ? limit : '0;
      if (dir) begin
         step_val = (out_q >= limit) ? '0 : out_q + WIDTH'(1);
      end else begin
         step_val = (out_q == '0) ? limit : out_q - WIDTH'(1);
      end
      at_term = (step_val == term_val);
   end

   // Next count, pulse and one-shot state, in priority order
   // clear > load > start > step. Leaving one-shot mode drops back to IDLE.
   always_comb begin
      out_d   = out_q;
      tc_d    = 1'b0;
      restart = 1'b0;
      state_d = is_oneshot ? state_q : IDLE;
      if (clear) begin
         out_d   = '0;
         restart = 1'b1;
         state_d = IDLE;
      end else if (load) begin
         out_d   = load_val;
         restart = 1'b1;
      end else if (is_oneshot && start && (state_q != RUN)) begin
         out_d   = dir ? '0 : limit;
         restart = 1'b1;
         state_d = RUN;
      end else if (tick) begin
         if (is_oneshot) begin
            if (state_q == RUN) begin
               out_d = step_val;
               tc_d  = at_term;
               if (at_term) begin
                  state_d = DONE;
               end
            end
         end else if (!(is_sat && (out_q == term_val))) begin
            out_d = step_val;
            tc_d  = at_term;
         end
      end
   end

   // Count, pulse and state registers; reset abandons any operation.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_q   <= '0;
         tc_q    <= 1'b0;
         state_q <= IDLE;
      end else begin
         out_q   <= out_d;
         tc_q    <= tc_d;
         state_q <= state_d;
      end
   end

   assign out  = out_q;
   assign tc   = tc_q;
   assign busy = is_oneshot ? (state_q == RUN) : en;

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: stimulus pushes the expected post-edge
// outputs into a queue and a monitor pops and compares after each edge.
module tb_prog_counter;
   import prog_counter_pkg::*;

   logic       clock;
   logic       reset_n;
   logic       en;
   logic       clear;
   logic       load;
   logic [7:0] load_val;
   logic [7:0] limit;
   logic       dir;
   logic [1:0] mode;
   logic       start;
   logic [3:0] div;
   logic [7:0] out;
   logic       tc;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_out_q[$];
   logic       exp_tc_q[$];
   logic       exp_busy_q[$];
   string      exp_nm_q[$];

   prog_counter #(
      .WIDTH    (8),
      .DIV_WIDTH(4)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (en),
      .clear   (clear),
      .load    (load),
      .load_val(load_val),
      .limit   (limit),
      .dir     (dir),
      .mode    (mode),
      .start   (start),
      .div     (div),
      .out     (out),
      .tc      (tc),
      .busy    (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [7:0] eo, input logic et, input logic eb);
      checks++;
      if (out !== eo || tc !== et || busy !== eb) begin
         failures++;
         $display("FAIL %s: got out=%0d tc=%0b busy=%0b, expected out=%0d tc=%0b busy=%0b",
                  nm, out, tc, busy, eo, et, eb);
      end else begin
         $display("ok   %s: out=%0d tc=%0b busy=%0b", nm, out, tc, busy);
      end
   endtask

   // Called at a falling edge with inputs already set: queue the outputs
   // expected after the next rising edge, then move to the next falling edge.
   task automatic expect_cycle(input logic [7:0] eo, input logic et, input logic eb, input string nm);
      exp_out_q.push_back(eo);
      exp_tc_q.push_back(et);
      exp_busy_q.push_back(eb);
      exp_nm_q.push_back(nm);
      @(negedge clock);
   endtask

   // Monitor: compare the oldest expectation just after each rising edge.
   always @(posedge clock) begin
      #1;
      if (exp_out_q.size() != 0) begin
         check(exp_nm_q.pop_front(), exp_out_q.pop_front(),
               exp_tc_q.pop_front(), exp_busy_q.pop_front());
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b0;
      en       = 1'b0;
      clear    = 1'b0;
      load     = 1'b0;
      load_val = 8'd0;
      limit    = 8'd0;
      dir      = 1'b1;
      mode     = MODE_WRAP;
      start    = 1'b0;
      div      = 4'd0;

      @(negedge clock);
      expect_cycle(8'd0, 1'b0, 1'b0, "reset_state");
      reset_n = 1'b1;

      // Wrap up, limit 5, every cycle a tick.
      limit = 8'd5; div = 4'd0; en = 1'b1;
      expect_cycle(8'd1, 1'b0, 1'b1, "wrap_up_1");
      expect_cycle(8'd2, 1'b0, 1'b1, "wrap_up_2");
      expect_cycle(8'd3, 1'b0, 1'b1, "wrap_up_3");
      expect_cycle(8'd4, 1'b0, 1'b1, "wrap_up_4");
      expect_cycle(8'd5, 1'b1, 1'b1, "wrap_up_5_tc");
      expect_cycle(8'd0, 1'b0, 1'b1, "wrap_up_0");
      expect_cycle(8'd1, 1'b0, 1'b1, "wrap_up_1b");
      clear = 1'b1;
      expect_cycle(8'd0, 1'b0, 1'b1, "clear");
      clear = 1'b0;

      // Wrap down, limit 3, div 2: one step every three cycles.
      dir = 1'b0; limit = 8'd3; div = 4'd2; load = 1'b1; load_val = 8'd3;
      expect_cycle(8'd3, 1'b0, 1'b1, "down_load3");
      load = 1'b0;
      expect_cycle(8'd3, 1'b0, 1'b1, "down_p1");
      expect_cycle(8'd3, 1'b0, 1'b1, "down_p2");
      expect_cycle(8'd2, 1'b0, 1'b1, "down_2");
      expect_cycle(8'd2, 1'b0, 1'b1, "down_p1b");
      expect_cycle(8'd2, 1'b0, 1'b1, "down_p2b");
      expect_cycle(8'd1, 1'b0, 1'b1, "down_1");
      expect_cycle(8'd1, 1'b0, 1'b1, "down_p1c");
      expect_cycle(8'd1, 1'b0, 1'b1, "down_p2c");
      expect_cycle(8'd0, 1'b1, 1'b1, "down_0_tc");
      expect_cycle(8'd0, 1'b0, 1'b1, "down_p1d");
      expect_cycle(8'd0, 1'b0, 1'b1, "down_p2d");
      expect_cycle(8'd3, 1'b0, 1'b1, "down_reload3");
      // Prescaler holds while en is low.
      en = 1'b0;
      expect_cycle(8'd3, 1'b0, 1'b0, "en_low_1");
      expect_cycle(8'd3, 1'b0, 1'b0, "en_low_2");
      en = 1'b1;
      expect_cycle(8'd3, 1'b0, 1'b1, "en_resume_p1");
      expect_cycle(8'd3, 1'b0, 1'b1, "en_resume_p2");
      expect_cycle(8'd2, 1'b0, 1'b1, "en_resume_2");

      // Saturate up, limit 2.
      clear = 1'b1; mode = MODE_SAT; dir = 1'b1; limit = 8'd2; div = 4'd0;
      expect_cycle(8'd0, 1'b0, 1'b1, "sat_clear");
      clear = 1'b0;
      expect_cycle(8'd1, 1'b0, 1'b1, "sat_1");
      expect_cycle(8'd2, 1'b1, 1'b1, "sat_2_tc");
      expect_cycle(8'd2, 1'b0, 1'b1, "sat_hold_a");
      expect_cycle(8'd2, 1'b0, 1'b1, "sat_hold_b");

      // One-shot up, limit 4.
      mode = MODE_ONESHOT; limit = 8'd4;
      expect_cycle(8'd2, 1'b0, 1'b0, "os_idle_hold");
      start = 1'b1;
      expect_cycle(8'd0, 1'b0, 1'b1, "os_start");
      start = 1'b0;
      expect_cycle(8'd1, 1'b0, 1'b1, "os_1");
      expect_cycle(8'd2, 1'b0, 1'b1, "os_2");
      expect_cycle(8'd3, 1'b0, 1'b1, "os_3");
      expect_cycle(8'd4, 1'b1, 1'b0, "os_4_tc_done");
      expect_cycle(8'd4, 1'b0, 1'b0, "os_done_hold_a");
      expect_cycle(8'd4, 1'b0, 1'b0, "os_done_hold_b");
      start = 1'b1;
      expect_cycle(8'd0, 1'b0, 1'b1, "os_restart");
      start = 1'b0;
      expect_cycle(8'd1, 1'b0, 1'b1, "os_r1");
      start = 1'b1;
      expect_cycle(8'd2, 1'b0, 1'b1, "os_start_in_run_ignored");
      start = 1'b0;
      expect_cycle(8'd3, 1'b0, 1'b1, "os_r3");

      // Asynchronous reset in the middle of a one-shot run.
      reset_n = 1'b0;
      #1;
      check("rst_immediate", 8'd0, 1'b0, 1'b0);
      @(negedge clock);
      expect_cycle(8'd0, 1'b0, 1'b0, "rst_hold");
      reset_n = 1'b1;
      expect_cycle(8'd0, 1'b0, 1'b0, "rst_after_a");
      expect_cycle(8'd0, 1'b0, 1'b0, "rst_after_b");

      // clear beats load; then load, out above limit in both directions.
      mode = MODE_WRAP; en = 1'b0; clear = 1'b1; load = 1'b1; load_val = 8'd9;
      expect_cycle(8'd0, 1'b0, 1'b0, "clear_over_load");
      clear = 1'b0;
      expect_cycle(8'd9, 1'b0, 1'b0, "load9");
      load = 1'b0; en = 1'b1; dir = 1'b1; limit = 8'd5;
      expect_cycle(8'd0, 1'b0, 1'b1, "up_above_limit");
      load = 1'b1;
      expect_cycle(8'd9, 1'b0, 1'b1, "load_over_step");
      load = 1'b0; dir = 1'b0;
      expect_cycle(8'd8, 1'b0, 1'b1, "down_above_limit");

      // limit 0 in wrap: zero and a pulse on every tick.
      dir = 1'b1; limit = 8'd0;
      expect_cycle(8'd0, 1'b1, 1'b1, "limit0_a");
      expect_cycle(8'd0, 1'b1, 1'b1, "limit0_b");

      // Reserved mode behaves as wrap.
      mode = 2'b11; limit = 8'd5;
      expect_cycle(8'd1, 1'b0, 1'b1, "mode11_1");
      expect_cycle(8'd2, 1'b0, 1'b1, "mode11_2");

      // Leaving one-shot mode returns the FSM to IDLE.
      mode = MODE_ONESHOT; limit = 8'd4; start = 1'b1;
      expect_cycle(8'd0, 1'b0, 1'b1, "os_start2");
      start = 1'b0; mode = MODE_WRAP;
      expect_cycle(8'd1, 1'b0, 1'b1, "leave_os_wrap");
      mode = MODE_ONESHOT;
      expect_cycle(8'd1, 1'b0, 1'b0, "back_os_idle");

      // Let the monitor drain the queue.
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (exp_out_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_out_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (legal range 2..32).
REQ-002 SHALL have parameter DIV_WIDTH, default 4, prescaler divide-value width in bits.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, count enable; it also gates the prescaler.
REQ-006 SHALL have port clear, input, 1, synchronous clear.
REQ-007 SHALL have port load, input, 1, synchronous load of load_val.
REQ-008 SHALL have port load_val, input, WIDTH, value to load.
REQ-009 SHALL have port limit, input, WIDTH, terminal value when counting up and reload value when counting down.
REQ-010 SHALL have port dir, input, 1, count direction: 1 = up, 0 = down.
REQ-011 SHALL have port mode, input, 2, operating mode: 00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved, decoded as wrap.
REQ-012 SHALL have port start, input, 1, one-shot trigger; ignored in other modes.
REQ-013 SHALL have port div, input, DIV_WIDTH, prescale value; a count step is allowed every div+1 enabled cycles.
REQ-014 SHALL have port out, output, WIDTH, registered count value.
REQ-015 SHALL have port tc, output, 1, registered one-cycle terminal-count pulse.
REQ-016 SHALL have port busy, output, 1: equals en in wrap and saturate modes; high in the RUN state in one-shot mode.

Function
REQ-017 SHALL apply this priority, highest first: clear, then load, then start, then count step.
REQ-018 clear SHALL set out to 0, set the prescaler to 0, set the FSM to IDLE and hold tc low.
REQ-019 load SHALL set out to load_val and set the prescaler to 0; the FSM state is unchanged.
REQ-020 The prescaler SHALL count from 0 to div while en is high, then return to 0, and SHALL hold its value while en is low.
REQ-021 tick SHALL be high when en is high and the prescaler equals div; with div = 0, tick is high on every enabled cycle.
REQ-022 A count step SHALL occur only on a tick, and out SHALL change on the same clock edge (latency 1 cycle from the tick).
REQ-023 Terminal value SHALL be limit when dir = 1 and 0 when dir = 0.
REQ-024 An up step SHALL produce 0 if out >= limit, otherwise out+1.
REQ-025 A down step SHALL produce limit if out == 0, otherwise out-1.
REQ-026 In saturate mode, a step SHALL be suppressed when out already equals the terminal value.
REQ-027 tc SHALL be high for exactly the one cycle after each taken step whose result equals the terminal value; no tc is produced otherwise.
REQ-028 With limit = 0 in wrap mode, every tick SHALL produce out = 0 and a tc pulse.
REQ-029 All arithmetic SHALL be modulo 2^WIDTH, with no carry-out port.
REQ-030 The one-shot FSM SHALL have the states IDLE, RUN and DONE.
REQ-031 In the one-shot FSM: start in IDLE or DONE sets out to 0 (dir = 1) or to limit (dir = 0), zeroes the prescaler and enters RUN.
REQ-032 In the one-shot FSM: a RUN step reaching the terminal value pulses tc and enters DONE.
REQ-033 In the one-shot FSM: out holds in IDLE and DONE; start in RUN is ignored.
REQ-034 When mode changes away from one-shot, the FSM SHALL return to IDLE on the next edge.
REQ-035 Changes to limit, dir or div SHALL take effect on the next step with no restart; out > limit is handled per REQ-024 and REQ-025.

Reset
REQ-036 reset_n low SHALL immediately force out = 0, tc = 0, prescaler = 0 and FSM = IDLE, independent of clock.
REQ-037 Reset asserted mid-count or mid-one-shot SHALL abandon the operation; no tc SHALL be produced at or after deassertion until a new terminal step.
REQ-038 After deassertion, the first step SHALL occur no earlier than the first tick following the first rising edge.

Structure
REQ-039 Package prog_counter_pkg SHALL hold the mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and the FSM state enum.
REQ-040 The prescaler SHALL be a sub-module named prescaler with inputs clock, reset_n, en, restart and div, and output tick.
REQ-041 busy SHALL be derived combinationally from registered state and en; out and tc SHALL be flops.

Verification
REQ-042 WIDTH=8, limit=5, div=0, wrap, up, en=1 -> out 0,1,2,3,4,5,0,...; tc high the cycle after out becomes 5.
REQ-043 Down, limit=3, div=2, wrap -> out steps every 3 cycles 3,2,1,0,3; tc once per visit to 0.
REQ-044 Saturate, up, limit=2, from 0 -> out 1,2,2,2; exactly one tc pulse.
REQ-045 One-shot, up, limit=4, start pulse -> busy high, out 0..4, tc at 4, DONE holds 4; second start -> restarts from 0.
REQ-046 clear and load both asserted with load_val=9 -> out = 0; reset_n pulsed low mid-RUN -> out = 0, busy low, no tc.
